// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
// Multi-cycle 16-bit unsigned MULTU / DIVU sequencer that borrows the shared
// single-cycle ALU: shift-add multiply, restoring divide.
// Ports:
//   clk, reset          - clock (rising edge), async active-high reset
//   start, op           - request pulse; op 0 = MULTU, 1 = DIVU
//   opA, opB            - multiplicand/dividend, multiplier/divisor
//   aluResult           - combinational ALUout returned by the shared ALU
//   aluSrcA/B, aluCtrl  - ALU drive, valid while aluOwn=1 (else held at 0)
//   aluOwn, busy        - high in MUL/DIV_CMP/DIV_SUB
//   done                - one-cycle pulse, hi/lo valid
//   hi, lo              - {hi,lo}=product; lo=quotient, hi=remainder
module alu_muldiv_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [WIDTH-1:0] aluResult,
    output logic [WIDTH-1:0] aluSrcA,
    output logic [WIDTH-1:0] aluSrcB,
    output logic [2:0]       aluCtrl,
    output logic             aluOwn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_DIV_CMP, S_DIV_SUB, S_DONE
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    // During a divide hi_q holds the partial remainder and lo_q the
    // dividend/quotient shift register, so DONE needs no extra copy.
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand or divisor
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ge_q, ge_d;         // shifted remainder >= divisor
    logic             carry;
    logic [WIDTH-1:0] sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            ge_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            ge_q    <= ge_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        ge_d    = ge_q;
        aluSrcA = '0;
        aluSrcB = '0;
        aluCtrl = 3'b000;
        carry   = 1'b0;
        sh      = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    cnt_d = '0;
                    if (!op) begin
                        state_d = S_MUL;
                        hi_d    = '0;
                        lo_d    = opB;
                        mcand_d = opA;
                    end else if (opB != '0) begin
                        state_d = S_DIV_CMP;
                        hi_d    = '0;
                        lo_d    = opA;
                        mcand_d = opB;
                    end else begin
                        // divide by zero: finish at once without the ALU
                        state_d = S_DONE;
                        hi_d    = opA;
                        lo_d    = '1;
                    end
                end
            end
            S_MUL: begin
                aluCtrl = ALU_ADD;
                aluSrcA = hi_q;
                aluSrcB = lo_q[0] ? mcand_q : '0;
                // unsigned overflow of the add is the bit shifted into hi
                carry   = (aluResult < hi_q);
                hi_d    = {carry, aluResult[WIDTH-1:1]};
                lo_d    = {aluResult[0], lo_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) state_d = S_DONE;
            end
            S_DIV_CMP: begin
                aluCtrl = ALU_SLT;
                aluSrcA = sh;
                aluSrcB = mcand_q;
                // a bit shifted out of rem means the true value exceeds dvsr
                ge_d    = hi_q[WIDTH-1] | ~aluResult[0];
                hi_d    = sh;
                lo_d    = {lo_q[WIDTH-2:0], 1'b0};
                state_d = S_DIV_SUB;
            end
            S_DIV_SUB: begin
                aluCtrl = ALU_SUB;
                aluSrcA = hi_q;
                aluSrcB = mcand_q;
                if (ge_q) begin
                    hi_d    = aluResult;
                    lo_d[0] = 1'b1;
                end
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == LAST_CNT) ? S_DONE : S_DIV_CMP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy   = (state_q == S_MUL) || (state_q == S_DIV_CMP) || (state_q == S_DIV_SUB);
    assign aluOwn = busy;
    assign done   = (state_q == S_DONE);
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule
